mem_stage_seq: RTL and testbench

- Parametrised successor to the single-shot memory stage: a sequenced scalar/vector load-store engine between the EX/MEM and MEM/WB pipe registers and a byte-wide data memory.
- Adds runtime vector length, per-lane mask, signed stride addressing, memory grant back-pressure, and a busy/done handshake that stalls the pipeline.
- Accesses one lane per granted cycle.

---
 rtl/mem_stage_seq.sv | 171 +++++++++++++++++
 tb/tb_mem_stage_seq.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_seq.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_seq
// Brief    : Sequenced scalar/vector load-store engine between the EX/MEM and
//            MEM/WB pipe registers and a byte-wide data memory.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_seq #(
    parameter int L = 8,
    parameter int V = 20,
    parameter int A = 32,
    parameter int S = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start_i,
    input  logic                    op_vec_i,
    input  logic                    write_i,
    input  logic [A-1:0]            base_addr_i,
    input  logic [S-1:0]            stride_i,
    input  logic [$clog2(V+1)-1:0]  vlen_i,
    input  logic [V-1:0]            mask_i,
    input  logic [V*L-1:0]          wdata_v_i,
    input  logic [L-1:0]            wdata_s_i,
    output logic                    mem_en_o,
    output logic                    mem_we_o,
    output logic [A-1:0]            mem_addr_o,
    output logic [L-1:0]            mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic [L-1:0]            mem_rdata_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [V*L-1:0]          rdata_v_o,
    output logic [L-1:0]            rdata_s_o
);

    localparam int VW = $clog2(V + 1);
    localparam int KW = (V > 1) ? $clog2(V) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_vec;
    logic            r_we;
    logic [A-1:0]    r_acc;
    logic [S-1:0]    r_stride;
    logic [VW-1:0]   r_vlen;
    logic [VW-1:0]   r_k;
    logic [V-1:0]    r_mask;
    logic [V*L-1:0]  r_wdata;
    logic            r_rd_pend;
    logic [KW-1:0]   r_rd_lane;
    logic [L-1:0]    r_rdata_s;

    logic [KW-1:0]   w_idx;
    logic            w_active;
    logic            w_adv;
    logic            w_last;
    logic            w_rd_gnt;
    logic            w_clr_v;
    logic            w_clr_s;
    logic [A-1:0]    w_stride_ext;
    logic [L-1:0]    w_wlane [V];

    assign w_idx        = r_k[KW-1:0];
    assign w_stride_ext = {{(A-S){r_stride[S-1]}}, r_stride};
    assign w_active     = (r_state == ST_ISSUE) && (r_vlen != '0) && r_mask[w_idx];
    assign w_adv        = (r_state == ST_ISSUE) && (!w_active || mem_gnt_i);
    assign w_last       = (r_k == r_vlen - VW'(1));
    assign w_rd_gnt     = w_active && mem_gnt_i && !r_we;
    assign w_clr_v      = (r_state == ST_IDLE) && start_i && op_vec_i && !write_i;
    assign w_clr_s      = (r_state == ST_IDLE) && start_i && !op_vec_i && !write_i;

    assign mem_en_o    = w_active;
    assign mem_we_o    = w_active && r_we;
    assign mem_addr_o  = w_active ? r_acc : '0;
    assign mem_wdata_o = w_active ? w_wlane[w_idx] : '0;
    assign busy_o      = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
    assign done_o      = (r_state == ST_DONE);
    assign rdata_s_o   = r_rdata_s;

    // Per-lane write-byte view and vector result register
    for (genvar g = 0; g < V; g++) begin : g_lane
        logic [L-1:0] r_rdata;

        assign w_wlane[g] = r_wdata[g*L +: L];

        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                r_rdata <= '0;
            end else if (w_clr_v) begin
                r_rdata <= '0;
            end else if (r_rd_pend && r_vec && (r_rd_lane == KW'(g))) begin
                r_rdata <= mem_rdata_i;
            end
        end

        assign rdata_v_o[g*L +: L] = r_rdata;
    end

    // A scalar op is run as a one-lane vector op with lane 0 always enabled
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= ST_IDLE;
            r_vec     <= 1'b0;
            r_we      <= 1'b0;
            r_acc     <= '0;
            r_stride  <= '0;
            r_vlen    <= '0;
            r_k       <= '0;
            r_mask    <= '0;
            r_wdata   <= '0;
            r_rd_pend <= 1'b0;
            r_rd_lane <= '0;
            r_rdata_s <= '0;
        end else begin
            // Read data returns one cycle after the grant, overlapping the next issue
            r_rd_pend <= w_rd_gnt;
            r_rd_lane <= w_idx;
            if (r_rd_pend && !r_vec) begin
                r_rdata_s <= mem_rdata_i;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_vec    <= op_vec_i;
                        r_we     <= write_i;
                        r_acc    <= base_addr_i;
                        r_stride <= stride_i;
                        r_k      <= '0;
                        if (op_vec_i) begin
                            r_vlen  <= (vlen_i > VW'(V)) ? VW'(V) : vlen_i;
                            r_mask  <= mask_i;
                            r_wdata <= wdata_v_i;
                        end else begin
                            r_vlen  <= VW'(1);
                            r_mask  <= V'(1);
                            r_wdata <= {{(V*L-L){1'b0}}, wdata_s_i};
                        end
                        if (w_clr_s) begin
                            r_rdata_s <= '0;
                        end
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_vlen == '0) begin
                        r_state <= ST_DONE;
                    end else if (w_adv) begin
                        r_k   <= r_k + VW'(1);
                        r_acc <= r_acc + w_stride_ext;
                        if (w_last) begin
                            r_state <= r_we ? ST_DONE : ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: r_state <= ST_DONE;
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_seq
// Brief    : Self-checking bench for mem_stage_seq with a lane-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_seq;

    localparam int L = 8;
    localparam int V = 20;
    localparam int A = 32;
    localparam int S = 8;

    logic            CLK = 1'b0;
    logic            RST;
    logic            start_i;
    logic            op_vec_i;
    logic            write_i;
    logic [A-1:0]    base_addr_i;
    logic [S-1:0]    stride_i;
    logic [4:0]      vlen_i;
    logic [V-1:0]    mask_i;
    logic [V*L-1:0]  wdata_v_i;
    logic [L-1:0]    wdata_s_i;
    logic            mem_en_o;
    logic            mem_we_o;
    logic [A-1:0]    mem_addr_o;
    logic [L-1:0]    mem_wdata_o;
    logic            mem_gnt_i;
    logic [L-1:0]    mem_rdata_i;
    logic            busy_o;
    logic            done_o;
    logic [V*L-1:0]  rdata_v_o;
    logic [L-1:0]    rdata_s_o;

    mem_stage_seq #(.L(L), .V(V), .A(A), .S(S)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start_i     (start_i),
        .op_vec_i    (op_vec_i),
        .write_i     (write_i),
        .base_addr_i (base_addr_i),
        .stride_i    (stride_i),
        .vlen_i      (vlen_i),
        .mask_i      (mask_i),
        .wdata_v_i   (wdata_v_i),
        .wdata_s_i   (wdata_s_i),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rdata_i (mem_rdata_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rdata_v_o   (rdata_v_o),
        .rdata_s_o   (rdata_s_o)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory device model
    logic [7:0] mem [bit [31:0]];
    logic [31:0] req_log [$];
    logic        rd_pend_n = 1'b0;
    logic [7:0]  rd_byte_n = 8'h00;
    int          gnt_mode  = 0;
    int          deny_cnt  = 0;
    logic [31:0] deny_addr = 32'h0;

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    always @(posedge CLK) begin
        #1;
        mem_rdata_i = rd_pend_n ? rd_byte_n : 8'($urandom);
        mem_gnt_i   = (gnt_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (deny_cnt > 0 && mem_en_o && mem_addr_o == deny_addr) begin
            mem_gnt_i = 1'b0;
            deny_cnt--;
        end
    end

    // Behavioural model: a queue of pending lane slots plus a tail of
    // post-issue cycles (drain + done for loads, done only for stores)
    typedef struct {
        bit          act;
        logic [31:0] addr;
        bit          we;
        logic [7:0]  dat;
    } slot_t;

    slot_t          q [$];
    int             m_tail = 0;
    logic [159:0]   exp_v  = '0;
    logic [7:0]     exp_s  = '0;
    logic           e_en, e_busy, e_done;

    task automatic launch();
        int    n;
        slot_t s;
        n = op_vec_i ? ((int'(vlen_i) > V) ? V : int'(vlen_i)) : 1;
        if (!write_i) begin
            if (op_vec_i) exp_v = '0;
            else          exp_s = '0;
        end
        if (n == 0) begin
            s.act = 1'b0; s.addr = '0; s.we = 1'b0; s.dat = '0;
            q.push_back(s);
            m_tail = 1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            s.act  = op_vec_i ? mask_i[k] : 1'b1;
            s.addr = base_addr_i + 32'($signed(stride_i)) * 32'(k);
            s.we   = write_i;
            s.dat  = op_vec_i ? wdata_v_i[k*8 +: 8] : wdata_s_i;
            if (s.act && !write_i) begin
                if (op_vec_i) exp_v[k*8 +: 8] = mem_rd(s.addr);
                else          exp_s = mem_rd(s.addr);
            end
            q.push_back(s);
        end
        m_tail = write_i ? 1 : 2;
    endtask

    // Compare process: every cycle, DUT outputs against the model
    always @(negedge CLK) begin
        if (!RST) begin
            chk("rst_en",   160'(mem_en_o),  160'(0));
            chk("rst_busy", 160'(busy_o),    160'(0));
            chk("rst_done", 160'(done_o),    160'(0));
            chk("rst_rv",   160'(rdata_v_o), 160'(0));
            chk("rst_rs",   160'(rdata_s_o), 160'(0));
            q.delete();
            m_tail    = 0;
            exp_v     = '0;
            exp_s     = '0;
            rd_pend_n = 1'b0;
        end else begin
            e_en   = (q.size() > 0) && q[0].act;
            e_busy = (q.size() > 0) || (m_tail == 2);
            e_done = (q.size() == 0) && (m_tail == 1);
            chk("en",   160'(mem_en_o), 160'(e_en));
            chk("busy", 160'(busy_o),   160'(e_busy));
            chk("done", 160'(done_o),   160'(e_done));
            if (e_en) begin
                chk("addr", 160'(mem_addr_o), 160'(q[0].addr));
                chk("we",   160'(mem_we_o),   160'(q[0].we));
                if (q[0].we) chk("wdata", 160'(mem_wdata_o), 160'(q[0].dat));
            end
            if (!e_busy) begin
                chk("rdata_v", rdata_v_o, exp_v);
                chk("rdata_s", 160'(rdata_s_o), 160'(exp_s));
            end
            rd_pend_n = 1'b0;
            if (mem_en_o && mem_gnt_i) begin
                req_log.push_back(mem_addr_o);
                if (mem_we_o) begin
                    mem[mem_addr_o] = mem_wdata_o;
                end else begin
                    rd_pend_n = 1'b1;
                    rd_byte_n = mem_rd(mem_addr_o);
                end
            end
            if (q.size() > 0) begin
                if (!q[0].act || mem_gnt_i) void'(q.pop_front());
            end else if (m_tail > 0) begin
                m_tail--;
            end else if (start_i) begin
                launch();
            end
        end
    end

    task automatic rand_fields();
        op_vec_i    = 1'($urandom_range(0, 1));
        write_i     = 1'($urandom_range(0, 1));
        base_addr_i = $urandom;
        stride_i    = 8'($urandom);
        vlen_i      = 5'($urandom_range(0, 25));
        mask_i      = 20'($urandom);
        for (int i = 0; i < 5; i++) wdata_v_i[i*32 +: 32] = $urandom;
        wdata_s_i   = 8'($urandom);
    endtask

    task automatic run_op(input bit vec, input bit wr, input logic [31:0] base,
                          input logic [7:0] stride, input logic [4:0] vlen,
                          input logic [19:0] mask, input logic [159:0] wdv,
                          input logic [7:0] wds, input bit noise, output int lat);
        bit got;
        @(posedge CLK); #1;
        op_vec_i = vec; write_i = wr; base_addr_i = base; stride_i = stride;
        vlen_i = vlen; mask_i = mask; wdata_v_i = wdv; wdata_s_i = wds;
        start_i = 1'b1;
        req_log.delete();
        @(posedge CLK); #1;
        start_i = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge CLK);
            if (done_o) begin
                got = 1'b1;
            end else begin
                @(posedge CLK); #1;
                lat++;
                if (noise) begin
                    rand_fields();
                    start_i = 1'($urandom_range(0, 1));
                end
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no done_o expected done_o within 400 cycles");
        end
        @(posedge CLK); #1;
        start_i = 1'b0;
    endtask

    int           lat;
    logic [159:0] wdv;

    initial begin
        RST = 1'b0; start_i = 1'b0; op_vec_i = 1'b0; write_i = 1'b0;
        base_addr_i = '0; stride_i = '0; vlen_i = '0; mask_i = '0;
        wdata_v_i = '0; wdata_s_i = '0; mem_gnt_i = 1'b1; mem_rdata_i = '0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;

        // Scalar store then load
        run_op(0, 1, 32'h10000, 8'd0, 5'd0, 20'd0, '0, 8'hA5, 0, lat);
        chk("sst_lat", 160'(lat), 160'(2));
        chk("sst_nreq", 160'(req_log.size()), 160'(1));
        chk("sst_addr", 160'(req_log[0]), 160'(32'h10000));
        run_op(0, 0, 32'h10000, 8'd0, 5'd0, 20'd0, '0, 8'h00, 0, lat);
        chk("sld_lat", 160'(lat), 160'(3));
        chk("sld_data", 160'(rdata_s_o), 160'(8'hA5));

        // Vector store lanes 0..15 = k, then load back
        wdv = '0;
        for (int k = 0; k < 16; k++) wdv[k*8 +: 8] = 8'(k);
        run_op(1, 1, 32'h10000, 8'd1, 5'd16, 20'hFFFFF, wdv, 8'h00, 0, lat);
        chk("vst_lat", 160'(lat), 160'(17));
        chk("vst_nreq", 160'(req_log.size()), 160'(16));
        chk("vst_last", 160'(req_log[15]), 160'(32'h1000F));
        run_op(1, 0, 32'h10000, 8'd1, 5'd16, 20'hFFFFF, '0, 8'h00, 0, lat);
        chk("vld_lat", 160'(lat), 160'(18));
        chk("vld_data", rdata_v_o, 160'h00000000_0f0e0d0c_0b0a0908_07060504_03020100);

        // Negative stride with address wrap
        run_op(1, 1, 32'h2, 8'hFF, 5'd4, 20'hFFFFF, wdv, 8'h00, 0, lat);
        chk("neg_a0", 160'(req_log[0]), 160'(32'h2));
        chk("neg_a1", 160'(req_log[1]), 160'(32'h1));
        chk("neg_a2", 160'(req_log[2]), 160'(32'h0));
        chk("neg_a3", 160'(req_log[3]), 160'(32'hFFFFFFFF));

        // Mask plus back-pressure on lane 2
        wdv = '0;
        wdv[7:0] = 8'h11;
        wdv[23:16] = 8'h22;
        deny_addr = 32'h20002;
        deny_cnt  = 3;
        run_op(1, 1, 32'h20000, 8'd1, 5'd20, 20'h00005, wdv, 8'h00, 0, lat);
        chk("msk_nreq", 160'(req_log.size()), 160'(2));
        chk("msk_a1", 160'(req_log[1]), 160'(32'h20002));
        chk("msk_lat", 160'(lat), 160'(24));
        run_op(1, 0, 32'h20000, 8'd1, 5'd20, 20'h00005, '0, 8'h00, 0, lat);
        chk("msk_ld", rdata_v_o, 160'h220011);
        chk("msk_ld_lat", 160'(lat), 160'(22));

        // vlen = 0 and clamped vlen
        run_op(1, 1, 32'h40000, 8'd1, 5'd0, 20'hFFFFF, wdv, 8'h00, 0, lat);
        chk("v0_lat", 160'(lat), 160'(2));
        chk("v0_nreq", 160'(req_log.size()), 160'(0));
        run_op(1, 0, 32'h30000, 8'd2, 5'd25, 20'hFFFFF, '0, 8'h00, 0, lat);
        chk("v25_nreq", 160'(req_log.size()), 160'(20));
        chk("v25_lat", 160'(lat), 160'(22));

        // start_i toggling while busy and in DONE
        run_op(1, 1, 32'h50000, 8'd3, 5'd8, 20'hFFFFF, wdv, 8'h00, 1, lat);
        chk("bsy_nreq", 160'(req_log.size()), 160'(8));
        chk("bsy_lat", 160'(lat), 160'(9));

        // Asynchronous reset during lane 5 of a 16-lane load
        @(posedge CLK); #1;
        op_vec_i = 1'b1; write_i = 1'b0; base_addr_i = 32'h10000; stride_i = 8'd1;
        vlen_i = 5'd16; mask_i = 20'hFFFFF; start_i = 1'b1;
        @(posedge CLK); #1;
        start_i = 1'b0;
        repeat (5) @(posedge CLK);
        #2;
        chk("rmid_addr", 160'(mem_addr_o), 160'(32'h10005));
        RST = 1'b0;
        #1;
        chk("arst_en",   160'(mem_en_o),  160'(0));
        chk("arst_busy", 160'(busy_o),    160'(0));
        chk("arst_rv",   160'(rdata_v_o), 160'(0));
        chk("arst_rs",   160'(rdata_s_o), 160'(0));
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        run_op(1, 0, 32'h10000, 8'd1, 5'd16, 20'hFFFFF, '0, 8'h00, 0, lat);
        chk("post_lat", 160'(lat), 160'(18));
        chk("post_data", rdata_v_o, 160'h00000000_0f0e0d0c_0b0a0908_07060504_03020100);

        // Randomized operations against the model
        for (int n = 0; n < 60; n++) begin
            logic [31:0]  b;
            logic [159:0] d;
            gnt_mode = int'($urandom_range(0, 1));
            b = ($urandom_range(0, 3) == 0) ? $urandom : 32'h10000 + 32'($urandom_range(0, 63));
            for (int i = 0; i < 5; i++) d[i*32 +: 32] = $urandom;
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), b, 8'($urandom),
                   5'($urandom_range(0, 25)), 20'($urandom), d, 8'($urandom), 1, lat);
            repeat ($urandom_range(0, 2)) @(posedge CLK);
        end

        repeat (3) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
